// File: rtl/rv_pkg.sv
// rv_pkg: ALU opcodes and default widths shared by the RS, ALU and decoder
package rv_pkg;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SRA = 3'd7;
  localparam int ROB_W_DEF = 4;
endpackage

// File: rtl/alu_rs_if.sv
// alu_rs_if: dispatch, CDB snoop and issue signals of the ALU reservation station
interface alu_rs_if import rv_pkg::*; #(parameter int ROB_W = ROB_W_DEF);
  logic             disp_valid;
  logic [2:0]       disp_op;
  logic [31:0]      disp_vj, disp_vk;
  logic [ROB_W-1:0] disp_qj, disp_qk;
  logic             disp_j_busy, disp_k_busy;
  logic [ROB_W-1:0] disp_rob;
  logic             full;
  logic             cdb_valid;
  logic [ROB_W-1:0] cdb_rob;
  logic [31:0]      cdb_value;
  logic             out_valid;
  logic [31:0]      out_rs1, out_rs2;
  logic [2:0]       out_op;
  logic [ROB_W-1:0] out_rob;
  modport master (
    output disp_valid, disp_op, disp_vj, disp_vk, disp_qj, disp_qk, disp_j_busy, disp_k_busy, disp_rob,
    output cdb_valid, cdb_rob, cdb_value,
    input  full, out_valid, out_rs1, out_rs2, out_op, out_rob
  );
  modport slave (
    input  disp_valid, disp_op, disp_vj, disp_vk, disp_qj, disp_qk, disp_j_busy, disp_k_busy, disp_rob,
    input  cdb_valid, cdb_rob, cdb_value,
    output full, out_valid, out_rs1, out_rs2, out_op, out_rob
  );
endinterface

// File: rtl/rs_pick.sv
// rs_pick: lowest-index priority encoder over a request vector
module rs_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);
  // scan from the top down so the lowest set bit wins
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = W'(i);
  end
endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station with CDB snoop, dispatch bypass and single issue
module alu_rs import rv_pkg::*; #(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = ROB_W_DEF
) (
  input logic     clk_in,
  input logic     rst_in,
  input logic     clear_in,
  alu_rs_if.slave bus
);
  localparam int IW = $clog2(RS_SIZE);
  logic [RS_SIZE-1:0] busy_q, busy_d, j_busy_q, j_busy_d, k_busy_q, k_busy_d;
  logic [2:0]         op_q [RS_SIZE];
  logic [2:0]         op_d [RS_SIZE];
  logic [31:0]        vj_q [RS_SIZE];
  logic [31:0]        vj_d [RS_SIZE];
  logic [31:0]        vk_q [RS_SIZE];
  logic [31:0]        vk_d [RS_SIZE];
  logic [ROB_W-1:0]   qj_q [RS_SIZE];
  logic [ROB_W-1:0]   qj_d [RS_SIZE];
  logic [ROB_W-1:0]   qk_q [RS_SIZE];
  logic [ROB_W-1:0]   qk_d [RS_SIZE];
  logic [ROB_W-1:0]   rob_q [RS_SIZE];
  logic [ROB_W-1:0]   rob_d [RS_SIZE];
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
  logic [2:0]         out_op_q, out_op_d;
  logic [ROB_W-1:0]   out_rob_q, out_rob_d;
  logic [RS_SIZE-1:0] free_vec, rdy_vec;
  logic [IW-1:0]      free_idx, rdy_idx;
  logic               free_any, rdy_any, j_hit, k_hit;
  // readiness and free slots come from registered state only
  always_comb begin
    free_vec = ~busy_q;
    rdy_vec  = busy_q & ~j_busy_q & ~k_busy_q;
  end
  rs_pick #(.N(RS_SIZE)) u_free (.req(free_vec), .idx(free_idx), .any(free_any));
  rs_pick #(.N(RS_SIZE)) u_rdy  (.req(rdy_vec),  .idx(rdy_idx),  .any(rdy_any));
  assign bus.full      = ~free_any;
  assign bus.out_valid = out_valid_q;
  assign bus.out_rs1   = out_rs1_q;
  assign bus.out_rs2   = out_rs2_q;
  assign bus.out_op    = out_op_q;
  assign bus.out_rob   = out_rob_q;
  // next state: snoop, issue, dispatch with CDB bypass; flush wins over all
  always_comb begin
    busy_d = busy_q;
    j_busy_d = j_busy_q;
    k_busy_d = k_busy_q;
    op_d = op_q;
    vj_d = vj_q;
    vk_d = vk_q;
    qj_d = qj_q;
    qk_d = qk_q;
    rob_d = rob_q;
    out_valid_d = rdy_any && !clear_in;
    out_rs1_d = out_valid_d ? vj_q[rdy_idx] : out_rs1_q;
    out_rs2_d = out_valid_d ? vk_q[rdy_idx] : out_rs2_q;
    out_op_d = out_valid_d ? op_q[rdy_idx] : out_op_q;
    out_rob_d = out_valid_d ? rob_q[rdy_idx] : out_rob_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (bus.cdb_valid && busy_q[i] && j_busy_q[i] && qj_q[i] == bus.cdb_rob) begin
        vj_d[i] = bus.cdb_value;
        j_busy_d[i] = 1'b0;
      end
      if (bus.cdb_valid && busy_q[i] && k_busy_q[i] && qk_q[i] == bus.cdb_rob) begin
        vk_d[i] = bus.cdb_value;
        k_busy_d[i] = 1'b0;
      end
    end
    if (out_valid_d) busy_d[rdy_idx] = 1'b0;
    j_hit = bus.cdb_valid && bus.disp_j_busy && bus.cdb_rob == bus.disp_qj;
    k_hit = bus.cdb_valid && bus.disp_k_busy && bus.cdb_rob == bus.disp_qk;
    if (bus.disp_valid && free_any) begin
      busy_d[free_idx] = 1'b1;
      op_d[free_idx] = bus.disp_op;
      vj_d[free_idx] = j_hit ? bus.cdb_value : bus.disp_vj;
      vk_d[free_idx] = k_hit ? bus.cdb_value : bus.disp_vk;
      qj_d[free_idx] = bus.disp_qj;
      qk_d[free_idx] = bus.disp_qk;
      j_busy_d[free_idx] = bus.disp_j_busy && !j_hit;
      k_busy_d[free_idx] = bus.disp_k_busy && !k_hit;
      rob_d[free_idx] = bus.disp_rob;
    end
    if (clear_in) busy_d = '0;
  end
  // state registers; reset also zeroes the issue data
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      out_valid_q <= 1'b0;
      out_rs1_q <= '0;
      out_rs2_q <= '0;
      out_op_q <= '0;
      out_rob_q <= '0;
    end else begin
      busy_q <= busy_d;
      out_valid_q <= out_valid_d;
      out_rs1_q <= out_rs1_d;
      out_rs2_q <= out_rs2_d;
      out_op_q <= out_op_d;
      out_rob_q <= out_rob_d;
    end
    j_busy_q <= j_busy_d;
    k_busy_q <= k_busy_d;
    op_q <= op_d;
    vj_q <= vj_d;
    vk_q <= vk_d;
    qj_q <= qj_d;
    qk_q <= qk_d;
    rob_q <= rob_d;
  end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed self-checking bench for the ALU reservation station
module tb_alu_rs;
  logic clk = 1'b0;
  logic rst, clr;
  int checks = 0;
  int errors = 0;
  alu_rs_if #(.ROB_W(4)) bus ();
  alu_rs #(.RS_SIZE(8), .ROB_W(4)) dut (.clk_in(clk), .rst_in(rst), .clear_in(clr), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic disp(input logic [2:0] op, input logic [31:0] vj, input logic [31:0] vk,
                      input logic jb, input logic [3:0] qj, input logic kb, input logic [3:0] qk,
                      input logic [3:0] rob);
    bus.disp_valid = 1'b1;
    bus.disp_op = op;
    bus.disp_vj = vj;
    bus.disp_vk = vk;
    bus.disp_j_busy = jb;
    bus.disp_qj = qj;
    bus.disp_k_busy = kb;
    bus.disp_qk = qk;
    bus.disp_rob = rob;
  endtask
  initial begin
    rst = 1'b1;
    clr = 1'b0;
    bus.disp_valid = 1'b0;
    bus.disp_op = '0;
    bus.disp_vj = '0;
    bus.disp_vk = '0;
    bus.disp_qj = '0;
    bus.disp_qk = '0;
    bus.disp_j_busy = 1'b0;
    bus.disp_k_busy = 1'b0;
    bus.disp_rob = '0;
    bus.cdb_valid = 1'b0;
    bus.cdb_rob = '0;
    bus.cdb_value = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_rs1", bus.out_rs1, 0);
    chk("rst_rob", 32'(bus.out_rob), 0);
    disp(3'd0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
    tick();
    bus.disp_valid = 1'b0;
    chk("t1_wait", 32'(bus.out_valid), 0);
    chk("t1_full", 32'(bus.full), 0);
    tick();
    chk("t1_valid", 32'(bus.out_valid), 1);
    chk("t1_rs1", bus.out_rs1, 5);
    chk("t1_rs2", bus.out_rs2, 7);
    chk("t1_op", 32'(bus.out_op), 0);
    chk("t1_rob", 32'(bus.out_rob), 3);
    chk("t1_full2", 32'(bus.full), 0);
    tick();
    chk("t1_drop", 32'(bus.out_valid), 0);
    chk("t1_hold", bus.out_rs1, 5);
    disp(3'd1, 32'd0, 32'd3, 1'b1, 4'd2, 1'b0, 4'd0, 4'd4);
    tick();
    bus.disp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_idle", 32'(bus.out_valid), 0);
    end
    bus.cdb_valid = 1'b1;
    bus.cdb_rob = 4'd2;
    bus.cdb_value = 32'h10;
    tick();
    bus.cdb_valid = 1'b0;
    chk("t2_nosame", 32'(bus.out_valid), 0);
    tick();
    chk("t2_valid", 32'(bus.out_valid), 1);
    chk("t2_rs1", bus.out_rs1, 32'h10);
    chk("t2_rs2", bus.out_rs2, 3);
    chk("t2_op", 32'(bus.out_op), 1);
    chk("t2_rob", 32'(bus.out_rob), 4);
    disp(3'd2, 32'd0, 32'd0, 1'b1, 4'd6, 1'b1, 4'd6, 4'd5);
    bus.cdb_valid = 1'b1;
    bus.cdb_rob = 4'd6;
    bus.cdb_value = 32'hFFFF_FFFF;
    tick();
    bus.disp_valid = 1'b0;
    bus.cdb_valid = 1'b0;
    tick();
    chk("t3_valid", 32'(bus.out_valid), 1);
    chk("t3_rs1", bus.out_rs1, 32'hFFFF_FFFF);
    chk("t3_rs2", bus.out_rs2, 32'hFFFF_FFFF);
    chk("t3_rob", 32'(bus.out_rob), 5);
    tick();
    for (int i = 0; i < 8; i++) begin
      disp(3'(i), 32'd0, 32'(i), 1'b1, 4'd1, 1'b0, 4'd0, 4'(i));
      tick();
    end
    chk("t4_full", 32'(bus.full), 1);
    disp(3'd0, 32'd9, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    tick();
    bus.disp_valid = 1'b0;
    chk("t4_full2", 32'(bus.full), 1);
    tick();
    chk("t4_dropped", 32'(bus.out_valid), 0);
    bus.cdb_valid = 1'b1;
    bus.cdb_rob = 4'd1;
    bus.cdb_value = 32'h100;
    tick();
    bus.cdb_valid = 1'b0;
    chk("t4_full3", 32'(bus.full), 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t4_valid", 32'(bus.out_valid), 1);
      chk("t4_rob", 32'(bus.out_rob), 32'(i));
      chk("t4_rs1", bus.out_rs1, 32'h100);
      chk("t4_rs2", bus.out_rs2, 32'(i));
      if (i == 0) chk("t4_unfull", 32'(bus.full), 0);
    end
    tick();
    chk("t4_done", 32'(bus.out_valid), 0);
    for (int i = 0; i < 3; i++) begin
      disp(3'd0, 32'd0, 32'd0, 1'b1, 4'd7, 1'b0, 4'd0, 4'(i));
      tick();
    end
    disp(3'd4, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd10);
    tick();
    bus.disp_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_valid", 32'(bus.out_valid), 0);
    chk("t5_full", 32'(bus.full), 0);
    chk("t5_hold", 32'(bus.out_rob), 7);
    bus.cdb_valid = 1'b1;
    bus.cdb_rob = 4'd7;
    bus.cdb_value = 32'h55;
    tick();
    bus.cdb_valid = 1'b0;
    tick();
    chk("t5_noissue", 32'(bus.out_valid), 0);
    tick();
    chk("t5_noissue2", 32'(bus.out_valid), 0);
    disp(3'd0, 32'd0, 32'd0, 1'b1, 4'd5, 1'b0, 4'd0, 4'd13);
    tick();
    disp(3'd3, 32'hAA, 32'hBB, 1'b0, 4'd0, 1'b0, 4'd0, 4'd12);
    tick();
    bus.disp_valid = 1'b0;
    tick();
    chk("t6_pre", 32'(bus.out_valid), 1);
    chk("t6_pre_rs1", bus.out_rs1, 32'hAA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid", 32'(bus.out_valid), 0);
    chk("t6_rs1", bus.out_rs1, 0);
    chk("t6_rs2", bus.out_rs2, 0);
    chk("t6_op", 32'(bus.out_op), 0);
    chk("t6_rob", 32'(bus.out_rob), 0);
    chk("t6_full", 32'(bus.full), 0);
    bus.cdb_valid = 1'b1;
    bus.cdb_rob = 4'd5;
    bus.cdb_value = 32'h77;
    tick();
    bus.cdb_valid = 1'b0;
    tick();
    chk("t6_noissue", 32'(bus.out_valid), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station for the integer ALU. Buffers dispatched ALU operations until both operands are available, snoops the common data bus (CDB) to capture pending operands, and issues one ready entry per cycle. Issued operands, opcode and destination ROB tag are registered straight into the `alu` operand inputs. Sits between the dispatch stage and `alu`. The ALU result plus the `out_rob` tag goes to the CDB arbiter.

## Interface
- `RS_SIZE`, 8: number of entries (power of two, ≥2)
- `ROB_W`, 4: ROB tag width
- `clk_in` input 1: clock
- `rst_in` input 1: synchronous, active-high reset
- `clear_in` input 1: flush (mispredict); invalidates all entries
- `disp_valid` input 1: dispatch request this cycle
- `disp_op` input 3: ALU opcode (0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra)
- `disp_vj`, `disp_vk` input 32: operand values, meaningful when the matching `disp_*_busy` is 0
- `disp_qj`, `disp_qk` input ROB_W: producer tags, meaningful when the matching busy is 1
- `disp_j_busy`, `disp_k_busy` input 1: operand still pending
- `disp_rob` input ROB_W: destination ROB tag
- `full` output 1: all entries occupied (combinational from state)
- `cdb_valid` input 1: CDB broadcast valid
- `cdb_rob` input ROB_W: broadcasting tag
- `cdb_value` input 32: broadcast value
- `out_valid` output 1: registered; `out_rs1`/`out_rs2`/`out_op`/`out_rob` are valid
- `out_rs1`, `out_rs2` output 32: registered operands to `alu`
- `out_op` output 3: registered opcode to `alu`
- `out_rob` output ROB_W: registered destination tag

## Operation
- Entry state: busy, op, vj, vk, qj, qk, j_busy, k_busy, rob.
- Dispatch: if `disp_valid && !full`, write the lowest-index free entry. `disp_valid` while `full` is ignored and nothing is written. Dispatcher must sample `full` first.
- Dispatch/CDB bypass: if `cdb_valid` and `cdb_rob == disp_qj` with `disp_j_busy`, store `cdb_value` as vj with j_busy=0. Same rule for k. Both operands may capture the same broadcast.
- Snoop: every busy entry with j_busy && qj==cdb_rob captures `cdb_value` and clears j_busy. Same for k.
- Ready = busy && !j_busy && !k_busy, evaluated on registered state only.
- Issue: lowest-index ready entry. Its fields go to the `out_*` registers, `out_valid`=1, and the entry is freed, all on the same edge. If no entry is ready, `out_valid`=0 and the `out_*` data registers hold their previous values.
- No backpressure: consumer accepts every `out_valid` cycle.
- `clear_in`: all busy=0 and `out_valid`=0 on the next edge. It overrides the same-cycle dispatch, snoop and issue.
- `rst_in`: same effect as clear. In addition `out_rs1`=`out_rs2`=0, `out_op`=0, `out_rob`=0. Mid-operation reset discards everything.

## Timing
- Entry dispatched at edge T with both operands ready → issued at edge T+1 → `out_valid` high during cycle T+1..T+2. Minimum dispatch-to-`out_valid` latency is 1 cycle after the write edge.
- CDB capture at edge T → earliest issue at edge T+1. There is no same-cycle snoop-to-issue path.
- A slot freed by issue at edge T is usable by dispatch from cycle T+1. `full` does not anticipate a same-cycle issue.
- Dispatch and issue in the same cycle are both allowed, to different entries.
- Throughput: 1 issue/cycle.
- After reset: `full`=0, `out_valid`=0.

## Structure
- Shared package (`rv_pkg`):
  - ALU opcode constants ALU_ADD..ALU_SRA (0..7), shared with `alu` and the decoder
  - ROB_W default
- Sub-module `rs_pick`: parameterised lowest-index priority encoder (request vector → index + any). Instantiated twice: free-slot select and ready select.

## Test plan
- Reset, then dispatch op=0, vj=5, vk=7, rob=3, both ready → `out_valid`=1 one cycle after the write edge with rs1=5, rs2=7, op=0, rob=3; `full`=0 throughout.
- Dispatch op=1 with j_busy, qj=2, rob=4; 3 idle cycles, no issue; CDB rob=2 value=0x10 → next cycle issue rs1=0x10, rob=4.
- Dispatch with qj=qk=6 while CDB broadcasts rob=6 value=0xFFFF_FFFF in the same cycle → issued next cycle with rs1=rs2=0xFFFF_FFFF.
- Fill 8 entries, all blocked on tag 1 → `full`=1 and a 9th dispatch is dropped. Broadcast tag 1 → 8 consecutive issues in index order, `full` deasserts after the first issue edge.
- With 3 pending entries and one issue under way, assert `clear_in` → `out_valid`=0 next cycle, a later CDB broadcast of the pending tag produces no issue, `full`=0.
- Assert `rst_in` mid-stream with a valid output → next cycle `out_valid`=0, `out_rs1`=0, `out_rob`=0, all entries free.
